// File: rtl/pat_scheduler.sv
// pat_scheduler
//   Frame sequencer between the pattern generators and the LED serial driver.
//   For every frame it walks LED index 0..NUM_LEDS-1, broadcasts the index to all
//   generators, waits for the active generator's colour (or substitutes black on
//   timeout), and offers the colour to the driver over valid/ready. The active
//   pattern is latched only at frame start, so a frame never mixes patterns.
//
//   Optional feature macro: PAT_SCHED_AUTO_CYCLE_EN
//     defined   : pattern_sel_in is ignored; the pattern advances by one (with wrap)
//                 every FRAMES_PER_PATTERN completed frames, starting at pattern 0.
//     undefined : pattern_sel_in is latched at every frame start.
//
// Ports
//   clk_in, rst_in            clock, synchronous active-high reset
//   frame_start_in            start-of-frame pulse (only honoured while idle)
//   pattern_sel_in            pattern for the next frame
//   next_led_request          LED index broadcast to the generators
//   pat_red/green/blue_in     packed generator colours, pattern p at [p*CW +: CW]
//   pat_valid_in              per-generator colour valid
//   red/green/blue_out        registered colour to the driver
//   led_index_out             index of the presented colour
//   color_valid_out           colour presented; color_ready_in accepts it
//   active_pattern_out        pattern of the current/last frame
//   busy_out                  high whenever a frame is in progress
//   frame_done_out            one-cycle pulse after the last LED is accepted
//   timeout_err_out           sticky generator-timeout flag, cleared by reset
module pat_scheduler #(
    parameter int NUM_LEDS           = 20,
    parameter int COLOR_WIDTH        = 8,
    parameter int NUM_PATTERNS       = 4,
    parameter int TIMEOUT_CYCLES     = 8,
    parameter int FRAMES_PER_PATTERN = 60,
    localparam int CounterWidth      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1,
    localparam int SelWidth          = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1
) (
    input  logic                                 clk_in,
    input  logic                                 rst_in,
    input  logic                                 frame_start_in,
    input  logic [SelWidth-1:0]                  pattern_sel_in,
    output logic [CounterWidth-1:0]              next_led_request,
    input  logic [NUM_PATTERNS*COLOR_WIDTH-1:0]  pat_red_in,
    input  logic [NUM_PATTERNS*COLOR_WIDTH-1:0]  pat_green_in,
    input  logic [NUM_PATTERNS*COLOR_WIDTH-1:0]  pat_blue_in,
    input  logic [NUM_PATTERNS-1:0]              pat_valid_in,
    output logic [COLOR_WIDTH-1:0]               red_out,
    output logic [COLOR_WIDTH-1:0]               green_out,
    output logic [COLOR_WIDTH-1:0]               blue_out,
    output logic [CounterWidth-1:0]              led_index_out,
    output logic                                 color_valid_out,
    input  logic                                 color_ready_in,
    output logic [SelWidth-1:0]                  active_pattern_out,
    output logic                                 busy_out,
    output logic                                 frame_done_out,
    output logic                                 timeout_err_out
);

    localparam int WaitWidth = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CounterWidth-1:0] LastLed  = CounterWidth'(NUM_LEDS - 1);
    localparam logic [WaitWidth-1:0]    WaitLast = WaitWidth'(TIMEOUT_CYCLES - 1);
    localparam logic [SelWidth-1:0]     LastPat  = SelWidth'(NUM_PATTERNS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_PRESENT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [CounterWidth-1:0]  led_q, led_d;
    logic [WaitWidth-1:0]     wait_cnt_q, wait_cnt_d;
    logic [SelWidth-1:0]      active_q, active_d;
    logic [COLOR_WIDTH-1:0]   red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic                     terr_q, terr_d;

    // Active generator's colour and valid.
    logic [COLOR_WIDTH-1:0]   sel_red, sel_green, sel_blue;
    logic                     sel_valid;
    assign sel_red   = pat_red_in[int'(active_q)*COLOR_WIDTH +: COLOR_WIDTH];
    assign sel_green = pat_green_in[int'(active_q)*COLOR_WIDTH +: COLOR_WIDTH];
    assign sel_blue  = pat_blue_in[int'(active_q)*COLOR_WIDTH +: COLOR_WIDTH];
    assign sel_valid = pat_valid_in[active_q];

    // Pattern to latch if a frame starts this cycle.
    logic [SelWidth-1:0]      start_pat;

`ifdef PAT_SCHED_AUTO_CYCLE_EN
    localparam int FcWidth = $clog2(FRAMES_PER_PATTERN + 1);
    localparam logic [FcWidth-1:0] FcMax = FcWidth'(FRAMES_PER_PATTERN);

    logic [FcWidth-1:0] frame_cnt_q, frame_cnt_d;
    logic               roll;
    logic               unused_sel;

    assign unused_sel = ^pattern_sel_in;
    // Counter saturates at FcMax, so the switch happens at the first start after
    // enough completed frames rather than mid-frame.
    assign roll = (frame_cnt_q >= FcMax);

    always_comb begin
        start_pat = active_q;
        if (roll) begin
            start_pat = (active_q == LastPat) ? '0 : active_q + SelWidth'(1);
        end
    end
`else
    always_comb begin
        start_pat = pattern_sel_in;
        if (int'(pattern_sel_in) >= NUM_PATTERNS) begin
            start_pat = '0;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        led_d      = led_q;
        wait_cnt_d = wait_cnt_q;
        active_d   = active_q;
        red_d      = red_q;
        green_d    = green_q;
        blue_d     = blue_q;
        terr_d     = terr_q;
`ifdef PAT_SCHED_AUTO_CYCLE_EN
        frame_cnt_d = frame_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (frame_start_in) begin
                    active_d   = start_pat;
                    led_d      = '0;
                    wait_cnt_d = '0;
                    state_d    = S_WAIT;
`ifdef PAT_SCHED_AUTO_CYCLE_EN
                    if (roll) frame_cnt_d = '0;
`endif
                end
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + WaitWidth'(1);
                // Cycle 0 lets the generators see the new index; valid is ignored.
                if ((wait_cnt_q != '0) && sel_valid) begin
                    red_d   = sel_red;
                    green_d = sel_green;
                    blue_d  = sel_blue;
                    state_d = S_PRESENT;
                end else if (wait_cnt_q >= WaitLast) begin
                    red_d   = '0;
                    green_d = '0;
                    blue_d  = '0;
                    terr_d  = 1'b1;
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (color_ready_in) begin
                    if (led_q == LastLed) begin
                        state_d = S_DONE;
                    end else begin
                        led_d      = led_q + CounterWidth'(1);
                        wait_cnt_d = '0;
                        state_d    = S_WAIT;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
`ifdef PAT_SCHED_AUTO_CYCLE_EN
                if (!roll) frame_cnt_d = frame_cnt_q + FcWidth'(1);
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= S_IDLE;
            led_q      <= '0;
            wait_cnt_q <= '0;
            active_q   <= '0;
            red_q      <= '0;
            green_q    <= '0;
            blue_q     <= '0;
            terr_q     <= 1'b0;
`ifdef PAT_SCHED_AUTO_CYCLE_EN
            frame_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            led_q      <= led_d;
            wait_cnt_q <= wait_cnt_d;
            active_q   <= active_d;
            red_q      <= red_d;
            green_q    <= green_d;
            blue_q     <= blue_d;
            terr_q     <= terr_d;
`ifdef PAT_SCHED_AUTO_CYCLE_EN
            frame_cnt_q <= frame_cnt_d;
`endif
        end
    end

    assign next_led_request   = led_q;
    assign led_index_out      = led_q;
    assign red_out            = red_q;
    assign green_out          = green_q;
    assign blue_out           = blue_q;
    assign color_valid_out    = (state_q == S_PRESENT);
    assign busy_out           = (state_q != S_IDLE);
    assign frame_done_out     = (state_q == S_DONE);
    assign active_pattern_out = active_q;
    assign timeout_err_out    = terr_q;

endmodule

// File: tb/tb_pat_scheduler.sv
module tb_pat_scheduler;

    localparam int NL = 20;
    localparam int NP = 4;
    localparam int CW = 8;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          frame_start_in;
    logic [1:0]    pattern_sel_in;
    logic [4:0]    next_led_request;
    logic [NP*CW-1:0] pat_red_in, pat_green_in, pat_blue_in;
    logic [NP-1:0] pat_valid_in;
    logic [CW-1:0] red_out, green_out, blue_out;
    logic [4:0]    led_index_out;
    logic          color_valid_out;
    logic          color_ready_in;
    logic [1:0]    active_pattern_out;
    logic          busy_out;
    logic          frame_done_out;
    logic          timeout_err_out;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    pat_scheduler #(
        .NUM_LEDS(NL), .COLOR_WIDTH(CW), .NUM_PATTERNS(NP),
        .TIMEOUT_CYCLES(8), .FRAMES_PER_PATTERN(2)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .frame_start_in(frame_start_in),
        .pattern_sel_in(pattern_sel_in), .next_led_request(next_led_request),
        .pat_red_in(pat_red_in), .pat_green_in(pat_green_in), .pat_blue_in(pat_blue_in),
        .pat_valid_in(pat_valid_in), .red_out(red_out), .green_out(green_out),
        .blue_out(blue_out), .led_index_out(led_index_out),
        .color_valid_out(color_valid_out), .color_ready_in(color_ready_in),
        .active_pattern_out(active_pattern_out), .busy_out(busy_out),
        .frame_done_out(frame_done_out), .timeout_err_out(timeout_err_out)
    );

    // Colour every generator p returns for LED i.
    function automatic logic [23:0] exp_rgb(int p, int i);
        logic [7:0] r, g, b;
        r = 8'(p * 64 + i);
        g = 8'(200 - 3 * i + p);
        b = 8'(p * 16 + 5 * i);
        return {r, g, b};
    endfunction

    // Generator model: answers the broadcast index combinationally.
    always_comb begin
        pat_red_in   = '0;
        pat_green_in = '0;
        pat_blue_in  = '0;
        for (int p = 0; p < NP; p++) begin
            {pat_red_in[p*CW +: CW], pat_green_in[p*CW +: CW], pat_blue_in[p*CW +: CW]} =
                exp_rgb(p, int'(next_led_request));
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({busy_out, color_valid_out, frame_done_out, timeout_err_out,
                    next_led_request, led_index_out, active_pattern_out,
                    red_out, green_out, blue_out});
    endfunction

    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    task automatic start_frame(input logic [1:0] sel);
        @(negedge clk_in);
        frame_start_in = 1'b1;
        pattern_sel_in = sel;
        @(negedge clk_in);
        frame_start_in = 1'b0;
    endtask

    // Consume one frame with ready high, checking every accepted colour.
    task automatic run_frame(input int p);
        int n = 0;
        int dones = 0;
        int extra = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (color_valid_out && color_ready_in) begin
                chk("frame_color", 64'({led_index_out, red_out, green_out, blue_out}),
                    64'({5'(n), exp_rgb(p, n)}));
                n++;
            end
            if (frame_done_out) dones++;
            if (dones > 0 && !busy_out) break;
            @(negedge clk_in);
        end
        chk("frame_led_count", 64'(n), 64'(NL));
        chk("frame_done_pulses", 64'(dones), 64'(1));
        chk("frame_pattern", 64'(active_pattern_out), 64'(p));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_in);
            if (frame_done_out || busy_out) extra++;
        end
        chk("idle_after_frame", 64'(extra), 64'(0));
    endtask

    typedef struct {
        logic       fs;
        logic [1:0] sel;
        logic [3:0] vld;
        logic       rdy;
        logic       e_busy;
        logic       e_cv;
        logic [4:0] e_led;
        logic [1:0] e_act;
        int         e_rgb;   // LED whose colour must be presented, -1 = none
    } vec_t;

    vec_t tbl[10];

    initial begin
        int k;
        rst_in = 1'b1;
        frame_start_in = 1'b0;
        pattern_sel_in = '0;
        pat_valid_in = '0;
        color_ready_in = 1'b0;

        repeat (2) @(negedge clk_in);
        chk("reset_outputs", all_outs(), 64'(0));
        rst_in = 1'b0;

`ifdef PAT_SCHED_AUTO_CYCLE_EN
        pat_valid_in = '1;
        color_ready_in = 1'b1;
        for (int f = 0; f < 9; f++) begin
            start_frame(2'd3);
            run_frame((f / 2) % NP);
        end
`else
        //           fs    sel   vld      rdy   busy  cv    led    act   rgb
        tbl[0] = '{1'b1, 2'd1, 4'b0000, 1'b0, 1'b1, 1'b0, 5'd0, 2'd1, -1};
        tbl[1] = '{1'b0, 2'd1, 4'b0010, 1'b0, 1'b1, 1'b0, 5'd0, 2'd1, -1};
        tbl[2] = '{1'b0, 2'd1, 4'b0010, 1'b0, 1'b1, 1'b1, 5'd0, 2'd1,  0};
        tbl[3] = '{1'b0, 2'd1, 4'b0000, 1'b0, 1'b1, 1'b1, 5'd0, 2'd1,  0};
        tbl[4] = '{1'b0, 2'd1, 4'b0000, 1'b1, 1'b1, 1'b0, 5'd1, 2'd1, -1};
        tbl[5] = '{1'b0, 2'd1, 4'b0001, 1'b1, 1'b1, 1'b0, 5'd1, 2'd1, -1};
        tbl[6] = '{1'b0, 2'd1, 4'b1101, 1'b1, 1'b1, 1'b0, 5'd1, 2'd1, -1};
        tbl[7] = '{1'b0, 2'd1, 4'b0010, 1'b0, 1'b1, 1'b1, 5'd1, 2'd1,  1};
        tbl[8] = '{1'b1, 2'd3, 4'b0000, 1'b1, 1'b1, 1'b0, 5'd2, 2'd1, -1};
        tbl[9] = '{1'b0, 2'd3, 4'b0000, 1'b0, 1'b1, 1'b0, 5'd2, 2'd1, -1};

        @(negedge clk_in);
        for (int i = 0; i < 10; i++) begin
            frame_start_in = tbl[i].fs;
            pattern_sel_in = tbl[i].sel;
            pat_valid_in   = tbl[i].vld;
            color_ready_in = tbl[i].rdy;
            @(negedge clk_in);
            chk($sformatf("vec%0d_ctrl", i),
                64'({busy_out, color_valid_out, frame_done_out, next_led_request, active_pattern_out}),
                64'({tbl[i].e_busy, tbl[i].e_cv, 1'b0, tbl[i].e_led, tbl[i].e_act}));
            if (tbl[i].e_rgb >= 0)
                chk($sformatf("vec%0d_color", i),
                    64'({led_index_out, red_out, green_out, blue_out}),
                    64'({5'(tbl[i].e_rgb), exp_rgb(int'(tbl[i].e_act), tbl[i].e_rgb)}));
        end
        frame_start_in = 1'b0;

        do_reset();
        chk("reset_mid_frame", all_outs(), 64'(0));

        // Full frame on pattern 1, plus minimum WAIT->valid latency.
        pat_valid_in = '1;
        color_ready_in = 1'b1;
        start_frame(2'd1);
        k = 0;
        while (!color_valid_out && k < 10) begin
            @(negedge clk_in);
            k++;
        end
        chk("min_latency", 64'(k), 64'(2));
        run_frame(1);

        // Driver stall with mid-frame select change and ignored frame_start.
        do_reset();
        color_ready_in = 1'b0;
        start_frame(2'd2);
        k = 0;
        while (!color_valid_out && k < 10) begin
            @(negedge clk_in);
            k++;
        end
        for (int c = 0; c < 5; c++) begin
            chk("stall_hold",
                64'({frame_done_out, color_valid_out, led_index_out, red_out, green_out, blue_out}),
                64'({1'b0, 1'b1, 5'd0, exp_rgb(2, 0)}));
            frame_start_in = (c == 1);
            pattern_sel_in = 2'd3;
            @(negedge clk_in);
        end
        frame_start_in = 1'b0;
        color_ready_in = 1'b1;
        run_frame(2);

        // Generator never answers: black after eight WAIT cycles, sticky error.
        do_reset();
        pat_valid_in = '0;
        color_ready_in = 1'b0;
        start_frame(2'd0);
        k = 0;
        while (!color_valid_out && k < 20) begin
            if (k == 7) chk("no_early_timeout_err", 64'(timeout_err_out), 64'(0));
            @(negedge clk_in);
            k++;
        end
        chk("timeout_cycles", 64'(k), 64'(8));
        chk("timeout_black", 64'({red_out, green_out, blue_out}), 64'(0));
        chk("timeout_err_set", 64'(timeout_err_out), 64'(1));
        pat_valid_in = '1;
        color_ready_in = 1'b1;
        repeat (12) @(negedge clk_in);
        chk("timeout_err_sticky", 64'(timeout_err_out), 64'(1));
        do_reset();
        chk("timeout_err_cleared", 64'(timeout_err_out), 64'(0));

        // Reset while LED 7 is presented, then a clean restart.
        start_frame(2'd3);
        k = 0;
        while (!(color_valid_out && led_index_out == 5'd7) && k < 100) begin
            @(negedge clk_in);
            k++;
        end
        chk("reached_led7", 64'(led_index_out), 64'(7));
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("reset_at_led7", all_outs(), 64'(0));
        rst_in = 1'b0;
        start_frame(2'd1);
        run_frame(1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
